// File: rtl/instruction_memory.sv
// instruction_memory: word-addressed 16-bit instruction store for the fetch stage.
// Reads are combinational and decode into op/rs/rt/rd. Writes are synchronous
// through InsMemRW/IDataIn. A synchronous reset reloads the built-in program.
module instruction_memory #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IAddress,
    input  logic        InsMemRW,
    input  logic [15:0] IDataIn,
    output logic [15:0] instruction,
    output logic [3:0]  op,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [3:0]  rd
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Built-in program image. Every word not listed below reads as zero.
    function automatic logic [15:0] default_word(input int idx);
        case (idx)
            0:       default_word = 16'h1012;
            1:       default_word = 16'h2345;
            2:       default_word = 16'h3678;
            3:       default_word = 16'hF9AB;
            default: default_word = 16'h0000;
        endcase
    endfunction

    // The storage powers up already holding the default program, so it can be
    // fetched before the first reset edge.
    logic [15:0] mem_q [DEPTH] = '{0: 16'h1012, 1: 16'h2345, 2: 16'h3678,
                                   3: 16'hF9AB, default: 16'h0000};
    logic [15:0] mem_d [DEPTH];

    logic [ADDR_BITS-1:0] addr;

    // Address bits at and above ADDR_BITS are ignored, so addresses wrap
    // modulo the depth.
    assign addr = IAddress[ADDR_BITS-1:0];

    if (ADDR_BITS < 16) begin : g_unused_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^IAddress[15:ADDR_BITS];
    end

    // Next memory contents. Reset reloads the whole image and takes priority
    // over a write in the same cycle.
    always_comb begin
        mem_d = mem_q;
        if (rst) begin
            // NOTE: this memory really does need a reset, because reset must
            // restore the program image. Every word gets reloaded, so the array
            // is built from flops and cannot be mapped onto a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = default_word(i);
            end
        end else if (InsMemRW) begin
            mem_d[addr] = IDataIn;
        end
    end

    // Storage register. A write becomes visible right after its clock edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment. Every flop then
        // samples its pre-edge value, which avoids simulation order races.
        mem_q <= mem_d;
    end

    // Combinational read. While reset is high the output is forced to a NOP.
    always_comb begin
        instruction = 16'h0000;
        if (!rst) begin
            instruction = mem_q[addr];
        end
    end

    assign op = instruction[15:12];
    assign rs = instruction[11:8];
    assign rt = instruction[7:4];
    assign rd = instruction[3:0];

endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: directed self-checking bench for instruction_memory.
// Expected values are hand-computed constants taken from the default program
// image and from the words this bench writes.
module tb_instruction_memory;

    logic        clk = 1'b0;
    logic        clk_run = 1'b1;
    logic        rst;
    logic [15:0] IAddress;
    logic        InsMemRW;
    logic [15:0] IDataIn;
    logic [15:0] instruction;
    logic [3:0]  op, rs, rt, rd;

    int checks = 0;
    int failures = 0;

    instruction_memory #(.ADDR_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .IAddress    (IAddress),
        .InsMemRW    (InsMemRW),
        .IDataIn     (IDataIn),
        .instruction (instruction),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd)
    );

    // The clock is gated so that the combinational read can be checked with
    // the clock stopped.
    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    // Watchdog: the run must always end on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_word(input string tag, input logic [15:0] expected);
        check(tag, instruction, expected);
        check({tag, "_op"}, {12'h000, op}, {12'h000, expected[15:12]});
        check({tag, "_rs"}, {12'h000, rs}, {12'h000, expected[11:8]});
        check({tag, "_rt"}, {12'h000, rt}, {12'h000, expected[7:4]});
        check({tag, "_rd"}, {12'h000, rd}, {12'h000, expected[3:0]});
    endtask

    initial begin
        rst      = 1'b0;
        IAddress = 16'd3;
        InsMemRW = 1'b0;
        IDataIn  = 16'h0000;

        // Contents before any reset edge are the default image.
        #1;
        check_word("time0_addr3", 16'hF9AB);

        // While reset is high, the outputs are forced to a NOP.
        rst = 1'b1;
        #1;
        check_word("rst_force_comb", 16'h0000);
        @(posedge clk); #1;
        check_word("rst_force_edge", 16'h0000);

        // Default read sweep.
        @(negedge clk);
        rst = 1'b0; IAddress = 16'd0;
        #1; check_word("sweep_addr0", 16'h1012);
        @(negedge clk); IAddress = 16'd1;
        #1; check_word("sweep_addr1", 16'h2345);
        @(negedge clk); IAddress = 16'd2;
        #1; check_word("sweep_addr2", 16'h3678);
        @(negedge clk); IAddress = 16'd3;
        #1; check_word("sweep_addr3", 16'hF9AB);

        // Unprogrammed word, then a wrapped address.
        @(negedge clk); IAddress = 16'd10;
        #1; check("unprog_addr10", instruction, 16'h0000);
        @(negedge clk); IAddress = 16'h0102;
        #1; check("wrap_0102", instruction, 16'h3678);

        // Write, then read back. The old data is shown before the edge.
        @(negedge clk);
        IAddress = 16'd5; InsMemRW = 1'b1; IDataIn = 16'hC3D4;
        #1; check("pre_write_addr5", instruction, 16'h0000);
        @(posedge clk); #1;
        check_word("post_write_addr5", 16'hC3D4);
        @(negedge clk); InsMemRW = 1'b0;

        // Read-only protection across several edges.
        IAddress = 16'd0; IDataIn = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1; check("readonly_addr0", instruction, 16'h1012);

        // Back-to-back writes. The last write to the same address wins.
        @(negedge clk); InsMemRW = 1'b1; IAddress = 16'd6; IDataIn = 16'hAAAA;
        @(negedge clk); IAddress = 16'd7; IDataIn = 16'hBBBB;
        @(negedge clk); IAddress = 16'd6; IDataIn = 16'hCCCC;
        @(negedge clk); InsMemRW = 1'b0;
        #1; check("b2b_addr6_last", instruction, 16'hCCCC);
        IAddress = 16'd7;
        #1; check("b2b_addr7", instruction, 16'hBBBB);
        IAddress = 16'h0105;
        #1; check("wrap_write_addr5", instruction, 16'hC3D4);

        // Overwrite word 1, then reset while a write is pending.
        @(negedge clk); InsMemRW = 1'b1; IAddress = 16'd1; IDataIn = 16'h7777;
        @(negedge clk); InsMemRW = 1'b0;
        #1; check("word1_written", instruction, 16'h7777);
        @(negedge clk);
        rst = 1'b1; InsMemRW = 1'b1; IAddress = 16'd2; IDataIn = 16'h5555;
        #1; check_word("rst_mid_comb", 16'h0000);
        @(posedge clk); #1;
        check_word("rst_mid_edge", 16'h0000);
        @(negedge clk); rst = 1'b0; InsMemRW = 1'b0;
        #1; check("restore_word2", instruction, 16'h3678);
        IAddress = 16'd1;
        #1; check("restore_word1", instruction, 16'h2345);
        IAddress = 16'd5;
        #1; check("restore_word5", instruction, 16'h0000);
        IAddress = 16'd6;
        #1; check("restore_word6", instruction, 16'h0000);

        // Stop the clock while it is low. The read must still follow IAddress.
        @(negedge clk); clk_run = 1'b0;
        #20; IAddress = 16'd3;
        #1; check_word("stopped_clk_addr3", 16'hF9AB);
        #7; IAddress = 16'd0;
        #1; check_word("stopped_clk_addr0", 16'h1012);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
